// File: rtl/enable_reload_counter_if.sv
// enable_reload_counter_if: control and status bundle for enable_reload_counter.
// Rev 1.0
`default_nettype none

interface enable_reload_counter_if #(
    parameter int width = 8
);
    logic             enable_in;
    logic             syncreset;
    logic             wr_en;
    logic [width-1:0] wr_data;
    logic             underflow_out;
    logic             toggle_out;
    logic [width-1:0] count_value;
    logic             reloading;

    modport master (
        output enable_in, syncreset, wr_en, wr_data,
        input  underflow_out, toggle_out, count_value, reloading
    );

    modport slave (
        input  enable_in, syncreset, wr_en, wr_data,
        output underflow_out, toggle_out, count_value, reloading
    );
endinterface

`default_nettype wire

// File: rtl/enable_reload_counter.sv
// enable_reload_counter: period down-counter with reload delay, underflow pulse and toggle output.
// Rev 1.0
`default_nettype none

module enable_reload_counter #(
    parameter int width       = 8,
    parameter int reloaddelay = 3
) (
    input  wire                             clk,
    input  wire                             reset_n,
    enable_reload_counter_if.slave          bus
);

    localparam int DW = (reloaddelay > 1) ? $clog2(reloaddelay) : 1;
    localparam logic [DW-1:0] DLY_INIT = (reloaddelay > 0) ? DW'(reloaddelay - 1) : '0;
    localparam bit NO_DELAY = (reloaddelay == 0);

    typedef enum logic [0:0] {
        ST_COUNT  = 1'b0,
        ST_RELOAD = 1'b1
    } state_t;

    state_t           state;
    logic [width-1:0] per;
    logic [width-1:0] count;
    logic [DW-1:0]    dly;
    logic             underflow;
    logic             toggle;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_COUNT;
            per       <= '0;
            count     <= '0;
            dly       <= '0;
            underflow <= 1'b0;
            toggle    <= 1'b0;
        end else if (bus.syncreset) begin
            // A write in the same cycle goes straight into the counter.
            if (bus.wr_en) begin
                per   <= bus.wr_data;
                count <= bus.wr_data;
            end else begin
                count <= per;
            end
            state     <= ST_COUNT;
            dly       <= '0;
            underflow <= 1'b0;
            toggle    <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (bus.wr_en) begin
                per <= bus.wr_data;
            end
            if (bus.enable_in) begin
                case (state)
                    ST_COUNT: begin
                        if (count != '0) begin
                            count <= count - width'(1);
                        end else begin
                            underflow <= 1'b1;
                            toggle    <= ~toggle;
                            if (NO_DELAY) begin
                                count <= per;
                            end else begin
                                state <= ST_RELOAD;
                                dly   <= DLY_INIT;
                            end
                        end
                    end
                    ST_RELOAD: begin
                        if (dly == '0) begin
                            count <= per;
                            state <= ST_COUNT;
                        end else begin
                            dly <= dly - DW'(1);
                        end
                    end
                    default: state <= ST_COUNT;
                endcase
            end
        end
    end

    assign bus.underflow_out = underflow;
    assign bus.toggle_out    = toggle;
    assign bus.count_value   = count;
    assign bus.reloading     = (state == ST_RELOAD);

endmodule

`default_nettype wire

// File: tb/tb_enable_reload_counter.sv
// tb_enable_reload_counter: directed checks of enable_reload_counter (reloaddelay 3 and 0 builds).
`default_nettype none

module tb_enable_reload_counter;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    enable_reload_counter_if #(.width(8)) bus  ();
    enable_reload_counter_if #(.width(8)) bus0 ();

    enable_reload_counter #(.width(8), .reloaddelay(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    enable_reload_counter #(.width(8), .reloaddelay(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_period(input logic [7:0] p);
        bus.wr_en = 1'b1; bus.wr_data = p;
        tick();
        bus.wr_en = 1'b0; bus.syncreset = 1'b1;
        tick();
        bus.syncreset = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.enable_in = 1'b1; bus.syncreset = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        tick();
        tick();
        if ({bus.count_value, bus.underflow_out, bus.toggle_out, bus.reloading} !== 11'd0) begin
            $display("FAIL reset_outputs: got cnt=%0d uf=%b tg=%b rl=%b, expected all 0",
                     bus.count_value, bus.underflow_out, bus.toggle_out, bus.reloading);
            n_err++;
        end
        n_cmp++;
        bus.enable_in = 1'b0; bus.syncreset = 1'b0; bus.wr_en = 1'b0;
        reset_n = 1'b1;
        tick();
        // per=0 after reset: first enable underflows, then every 4 ticks
        bus.enable_in = 1'b1;
        tick();
        if (bus.underflow_out !== 1'b1 || bus.reloading !== 1'b1) begin
            $display("FAIL first_enable_uf: got uf=%b rl=%b, expected uf=1 rl=1",
                     bus.underflow_out, bus.reloading);
            n_err++;
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.underflow_out !== 1'b0) begin
                $display("FAIL per0_gap: tick %0d got uf=%b, expected 0", i, bus.underflow_out);
                n_err++;
            end
            n_cmp++;
        end
        tick();
        if (bus.underflow_out !== 1'b1 || bus.toggle_out !== 1'b0) begin
            $display("FAIL per0_second_uf: got uf=%b tg=%b, expected uf=1 tg=0",
                     bus.underflow_out, bus.toggle_out);
            n_err++;
        end
        n_cmp++;
        bus.enable_in = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    task automatic test_count_sequence();
        int k;
        logic [7:0] exp_cnt;
        load_period(8'd5);
        if (bus.count_value !== 8'd5 || bus.toggle_out !== 1'b0 || bus.reloading !== 1'b0) begin
            $display("FAIL seq_start: got cnt=%0d tg=%b rl=%b, expected cnt=5 tg=0 rl=0",
                     bus.count_value, bus.toggle_out, bus.reloading);
            n_err++;
        end
        n_cmp++;
        bus.enable_in = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            k = i % 9;
            exp_cnt = (k >= 1 && k <= 5) ? 8'(5 - k) : ((k == 0) ? 8'd5 : 8'd0);
            if (bus.count_value !== exp_cnt) begin
                $display("FAIL seq_count: tick %0d got %0d, expected %0d", i, bus.count_value, exp_cnt);
                n_err++;
            end
            n_cmp++;
            if (bus.underflow_out !== (k == 6)) begin
                $display("FAIL seq_uf: tick %0d got %b, expected %b", i, bus.underflow_out, (k == 6));
                n_err++;
            end
            n_cmp++;
            if (bus.reloading !== (k >= 6)) begin
                $display("FAIL seq_reloading: tick %0d got %b, expected %b", i, bus.reloading, (k >= 6));
                n_err++;
            end
            n_cmp++;
            if (bus.toggle_out !== (i >= 6 && i < 15)) begin
                $display("FAIL seq_toggle: tick %0d got %b, expected %b", i, bus.toggle_out, (i >= 6 && i < 15));
                n_err++;
            end
            n_cmp++;
        end
        bus.enable_in = 1'b0;
        // Enable low: everything holds
        tick(); tick();
        if (bus.count_value !== 8'd5 || bus.toggle_out !== 1'b0 || bus.underflow_out !== 1'b0) begin
            $display("FAIL hold: got cnt=%0d tg=%b uf=%b, expected cnt=5 tg=0 uf=0",
                     bus.count_value, bus.toggle_out, bus.underflow_out);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_slow_enable();
        int pulses = 0, first = -1, second = -1, rl_clks = 0;
        load_period(8'd2);
        for (int c = 1; c <= 48; c++) begin
            bus.enable_in = (c % 4 == 1);
            tick();
            if (bus.underflow_out === 1'b1) begin
                pulses++;
                if (first < 0) first = c; else if (second < 0) second = c;
            end
            if (bus.reloading === 1'b1) rl_clks++;
        end
        bus.enable_in = 1'b0;
        if (pulses !== 2) begin
            $display("FAIL slow_pulses: got %0d high clks, expected 2", pulses);
            n_err++;
        end
        n_cmp++;
        if (second - first !== 24) begin
            $display("FAIL slow_period: got %0d clks, expected 24", second - first);
            n_err++;
        end
        n_cmp++;
        if (rl_clks !== 24) begin
            $display("FAIL slow_reloading: got %0d clks, expected 24", rl_clks);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_period_write_deferred();
        load_period(8'd10);
        bus.enable_in = 1'b1;
        tick(); tick(); tick();
        bus.enable_in = 1'b0; bus.wr_en = 1'b1; bus.wr_data = 8'd3;
        tick();
        bus.wr_en = 1'b0;
        if (bus.count_value !== 8'd7) begin
            $display("FAIL write_no_effect: got %0d, expected 7", bus.count_value);
            n_err++;
        end
        n_cmp++;
        bus.enable_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (bus.count_value !== 8'(7 - i)) begin
                $display("FAIL write_continue: tick %0d got %0d, expected %0d", i, bus.count_value, 7 - i);
                n_err++;
            end
            n_cmp++;
        end
        tick(); tick(); tick(); tick();
        bus.enable_in = 1'b0;
        if (bus.count_value !== 8'd3 || bus.reloading !== 1'b0) begin
            $display("FAIL write_next_load: got cnt=%0d rl=%b, expected cnt=3 rl=0",
                     bus.count_value, bus.reloading);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_syncreset_override();
        bus.syncreset = 1'b1;
        tick();
        bus.syncreset = 1'b0;
        bus.enable_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        if (bus.count_value !== 8'd3 || bus.toggle_out !== 1'b1) begin
            $display("FAIL sr_setup: got cnt=%0d tg=%b, expected cnt=3 tg=1", bus.count_value, bus.toggle_out);
            n_err++;
        end
        n_cmp++;
        tick(); tick(); tick();
        bus.syncreset = 1'b1;
        tick();
        bus.syncreset = 1'b0; bus.enable_in = 1'b0;
        if (bus.underflow_out !== 1'b0 || bus.count_value !== 8'd3 ||
            bus.toggle_out !== 1'b0 || bus.reloading !== 1'b0) begin
            $display("FAIL sr_override: got uf=%b cnt=%0d tg=%b rl=%b, expected uf=0 cnt=3 tg=0 rl=0",
                     bus.underflow_out, bus.count_value, bus.toggle_out, bus.reloading);
            n_err++;
        end
        n_cmp++;
        tick();
        if (bus.underflow_out !== 1'b0) begin
            $display("FAIL sr_no_late_uf: got %b, expected 0", bus.underflow_out);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_write_through();
        bus.syncreset = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'hA0;
        tick();
        bus.syncreset = 1'b0; bus.wr_en = 1'b0;
        if (bus.count_value !== 8'hA0) begin
            $display("FAIL write_through: got %h, expected a0", bus.count_value);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_in_reload();
        load_period(8'd1);
        bus.enable_in = 1'b1;
        tick(); tick();
        if (bus.reloading !== 1'b1 || bus.underflow_out !== 1'b1) begin
            $display("FAIL rr_setup: got rl=%b uf=%b, expected 1 1", bus.reloading, bus.underflow_out);
            n_err++;
        end
        n_cmp++;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; bus.enable_in = 1'b0;
        if ({bus.count_value, bus.underflow_out, bus.toggle_out, bus.reloading} !== 11'd0) begin
            $display("FAIL reset_in_reload: got cnt=%0d uf=%b tg=%b rl=%b, expected all 0",
                     bus.count_value, bus.underflow_out, bus.toggle_out, bus.reloading);
            n_err++;
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_zero_delay();
        bus0.wr_en = 1'b1; bus0.wr_data = 8'd1;
        tick();
        bus0.wr_en = 1'b0; bus0.syncreset = 1'b1;
        tick();
        bus0.syncreset = 1'b0; bus0.enable_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (bus0.underflow_out !== (i % 2 == 0) || bus0.reloading !== 1'b0 ||
                bus0.count_value !== ((i % 2 == 0) ? 8'd1 : 8'd0) ||
                bus0.toggle_out !== ((i / 2) % 2 == 1)) begin
                $display("FAIL zero_delay: tick %0d got uf=%b rl=%b cnt=%0d tg=%b, expected uf=%b rl=0 cnt=%0d tg=%b",
                         i, bus0.underflow_out, bus0.reloading, bus0.count_value, bus0.toggle_out,
                         (i % 2 == 0), (i % 2 == 0) ? 1 : 0, ((i / 2) % 2 == 1));
                n_err++;
            end
            n_cmp++;
        end
        bus0.enable_in = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.enable_in = 1'b0; bus.syncreset = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 8'd0;
        bus0.enable_in = 1'b0; bus0.syncreset = 1'b0; bus0.wr_en = 1'b0; bus0.wr_data = 8'd0;
        test_reset();
        test_count_sequence();
        test_slow_enable();
        test_period_write_deferred();
        test_syncreset_override();
        test_write_through();
        test_reset_in_reload();
        test_zero_delay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
